// File: rtl/als_sampler_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the PmodALS sampler controller.
package als_pkg;

  // Frame layout of the ADC081S021: 16 SCK periods, 8 data bits at indices 4..11.
  localparam int FRAME_BITS   = 16;
  localparam int DATA_FIRST   = 4;
  localparam int DATA_LAST    = 11;
  localparam int DATA_W       = DATA_LAST - DATA_FIRST + 1;
  localparam int SETUP_HALVES = 1;
  localparam int QUIET_HALVES = 2;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_QUIET,
    WAIT
  } als_state_t;

  // Full frame length in clk cycles: setup half, 16 full SCK periods, quiet halves.
  function automatic int frame_cycles(input int clk_div);
    return (SETUP_HALVES + 2 * FRAME_BITS + QUIET_HALVES) * clk_div;
  endfunction

endpackage

// File: rtl/als_sampler_ctrl_sck_gen.sv
// SCK generator: divides clk by CLK_DIV per half period while run is high,
// starting with a low half; sck is held high whenever it is not running.
module als_sck_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic fall_tick,
  output logic rise_tick,
  output logic half_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] half_cnt;
  logic             running;

  // Half-period counter and SCK level; the first running cycle drives sck low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      running  <= 1'b0;
      sck      <= 1'b1;
    end else if (!run) begin
      half_cnt <= '0;
      running  <= 1'b0;
      sck      <= 1'b1;
    end else if (!running) begin
      half_cnt <= '0;
      running  <= 1'b1;
      sck      <= 1'b0;
    end else if (half_cnt == CNT_LAST) begin
      half_cnt <= '0;
      sck      <= ~sck;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  // Ticks flag the last cycle of a half, i.e. the edge at which sck toggles.
  assign half_done = running && (half_cnt == CNT_LAST);
  assign rise_tick = half_done && !sck;
  assign fall_tick = half_done && sck;

endmodule

// File: rtl/als_sampler_ctrl.sv
// PmodALS conversion sequencer: frames each ADC conversion with CS/SCK, captures
// the 8 data bits, checks padding, and hands results out over valid/ready.
module als_sampler_ctrl
  import als_pkg::*;
#(
  parameter int CLK_DIV  = 25,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                continuous,
  input  logic                start,
  input  logic [PERIOD_W-1:0] period,
  input  logic                sdo,
  output logic                sck,
  output logic                cs_n,
  output logic [7:0]          sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                frame_err,
  output logic                busy
);

  localparam int FRAME_CYC = frame_cycles(CLK_DIV);
  localparam logic [PERIOD_W-1:0] FRAME_CYC_P = PERIOD_W'(FRAME_CYC);
  localparam int TMR_W = $clog2(QUIET_HALVES * CLK_DIV + 1);
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(SETUP_HALVES * CLK_DIV - 1);
  localparam logic [TMR_W-1:0] QUIET_LAST = TMR_W'(QUIET_HALVES * CLK_DIV - 1);
  localparam int IDX_W = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_FIRST = IDX_W'(DATA_FIRST);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST  = IDX_W'(DATA_LAST);

  als_state_t          state;
  als_state_t          next_state;
  logic [TMR_W-1:0]    tmr;
  logic [IDX_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   data_reg;
  logic                pad_err;
  logic [PERIOD_W-1:0] since_start;
  logic [PERIOD_W-1:0] period_eff;
  logic                cont_lat;
  logic                sck_run;
  logic                fall_tick;
  logic                rise_tick;
  logic                half_done;
  logic                frame_start;
  logic                period_reached;
  logic                auto_go;
  logic                quiet_first;
  logic                shift_last;
  logic                is_data_bit;

  assign frame_start    = (next_state == CS_SETUP) && (state != CS_SETUP);
  assign period_reached = since_start >= (period_eff - 1'b1);
  assign auto_go        = cont_lat && continuous && enable;
  assign quiet_first    = (state == CS_QUIET) && (tmr == '0);
  assign shift_last     = half_done && sck && (bit_idx == IDX_LAST);
  assign is_data_bit    = (bit_idx >= IDX_DATA_FIRST) && (bit_idx <= IDX_DATA_LAST);
  assign sck_run        = (next_state == SHIFT);

  als_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (sck_run),
    .sck       (sck),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick),
    .half_done (half_done)
  );

  // State register; an async reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; back-to-back frames skip WAIT when the period has already elapsed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (enable && (continuous || start)) begin
          next_state = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (tmr == SETUP_LAST) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_last) begin
          next_state = CS_QUIET;
        end
      end
      CS_QUIET: begin
        if (tmr == QUIET_LAST) begin
          if (auto_go) begin
            next_state = period_reached ? CS_SETUP : WAIT;
          end else begin
            next_state = IDLE;
          end
        end
      end
      WAIT: begin
        if (!enable || !continuous) begin
          next_state = IDLE;
        end else if (period_reached) begin
          next_state = CS_SETUP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Chip select and busy follow the state directly so reset releases CS at once.
  always_comb begin
    cs_n = 1'b1;
    busy = 1'b0;
    case (state)
      CS_SETUP, SHIFT: begin
        cs_n = 1'b0;
        busy = 1'b1;
      end
      CS_QUIET: begin
        busy = 1'b1;
      end
      default: begin
        cs_n = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  // Cycle timer for the CS setup and quiet phases, restarted on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (next_state != state) begin
      tmr <= '0;
    end else if ((state == CS_SETUP) || (state == CS_QUIET)) begin
      tmr <= tmr + 1'b1;
    end else begin
      tmr <= '0;
    end
  end

  // Frame scheduling: latch period/mode at frame start and count cycles since then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since_start <= '0;
      period_eff  <= '0;
      cont_lat    <= 1'b0;
    end else if (frame_start) begin
      since_start <= '0;
      period_eff  <= (period > FRAME_CYC_P) ? period : FRAME_CYC_P;
      cont_lat    <= continuous;
    end else if (since_start != '1) begin
      since_start <= since_start + 1'b1;
    end
  end

  // Bit capture on SCK rise: data bits shift in MSB first, any padding 1 flags an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx  <= '0;
      data_reg <= '0;
      pad_err  <= 1'b0;
    end else if (state == CS_SETUP) begin
      bit_idx  <= '0;
      data_reg <= '0;
      pad_err  <= 1'b0;
    end else if (state == SHIFT) begin
      if (rise_tick) begin
        if (is_data_bit) begin
          data_reg <= {data_reg[DATA_W-2:0], sdo};
        end else if (sdo) begin
          pad_err <= 1'b1;
        end
      end
      if (fall_tick && (bit_idx != IDX_LAST)) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Result delivery and handshake; a new result outranks a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      frame_err    <= 1'b0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (quiet_first) begin
      sample       <= data_reg;
      frame_err    <= pad_err;
      sample_valid <= 1'b1;
      overrun      <= sample_valid && !sample_ready;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_als_sampler_ctrl.sv
// Scoreboard bench for als_sampler_ctrl with CLK_DIV=2 (70-cycle frames).
module tb_als_sampler_ctrl;

  localparam int CLK_DIV  = 2;
  localparam int PERIOD_W = 24;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic                continuous = 1'b0;
  logic                start = 1'b0;
  logic [PERIOD_W-1:0] period = '0;
  logic                sdo = 1'b0;
  logic                sample_ready = 1'b0;
  logic                sck;
  logic                cs_n;
  logic [7:0]          sample;
  logic                sample_valid;
  logic                overrun;
  logic                frame_err;
  logic                busy;

  typedef struct {
    logic [7:0] sample;
    logic       frame_err;
    logic       overrun;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          sck_falls = 0;
  int          cs_falls = 0;
  int          bit_i = 0;
  logic [15:0] frame_bits = '0;

  als_sampler_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .continuous   (continuous),
    .start        (start),
    .period       (period),
    .sdo          (sdo),
    .sck          (sck),
    .cs_n         (cs_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Sensor model: a new frame starts at CS fall, each SCK fall presents the next bit.
  always @(negedge cs_n) begin
    cs_falls++;
    bit_i = 0;
    sdo = 1'b0;
  end

  always @(negedge sck) begin
    if (cs_n == 1'b0) begin
      sck_falls++;
      if (bit_i < 16) sdo = frame_bits[15 - bit_i];
      bit_i++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sample_valid === 1'b1 && sample_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected result: got sample 0x%0h, expected none", sample);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb sample", 32'(sample), 32'(mon_e.sample));
        checkOutput("sb frame_err", 32'(frame_err), 32'(mon_e.frame_err));
        checkOutput("sb overrun", 32'(overrun), 32'(mon_e.overrun));
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] bits, input logic [7:0] exp_sample,
                               input logic exp_err, input logic exp_ovr);
    exp_t e;
    frame_bits = bits;
    e.sample = exp_sample;
    e.frame_err = exp_err;
    e.overrun = exp_ovr;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic acceptOne();
    sample_ready = 1'b1;
    @(posedge clk);
    #1;
    sample_ready = 1'b0;
  endtask

  // kind: 0 valid high, 1 overrun high, 2 busy low, 3 cs_n falling
  task automatic waitEvent(input int kind, input int limit, input string name, output int cyc);
    logic prev;
    logic hit;
    prev = cs_n;
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      case (kind)
        0: hit = (sample_valid === 1'b1);
        1: hit = (overrun === 1'b1);
        2: hit = (busy === 1'b0);
        default: hit = (prev === 1'b1) && (cs_n === 1'b0);
      endcase
      prev = cs_n;
      if (hit) begin
        cyc = i;
        return;
      end
    end
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out after %0d cycles, expected event", name, limit);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    int c1;
    int c2;
    int cs0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cs_n", 32'(cs_n), 32'd1);
    checkOutput("reset sck", 32'(sck), 32'd1);
    checkOutput("reset sample", 32'(sample), 32'd0);
    checkOutput("reset valid", 32'(sample_valid), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    checkOutput("reset frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] one-shot frame, data 0xB3");
    enable = 1'b1;
    continuous = 1'b0;
    applyStimulus(16'b0000_1011_0011_0000, 8'hB3, 1'b0, 1'b0);
    sck_falls = 0;
    pulseStart();
    waitEvent(0, 200, "oneshot valid", c);
    checkOutput("oneshot latency", 32'(c), 32'd67);
    checkOutput("oneshot sck falls", 32'(sck_falls), 32'd16);
    waitEvent(2, 20, "oneshot busy drop", c);
    checkOutput("oneshot busy drop time", 32'(c), 32'd3);
    checkOutput("oneshot cs_n idle", 32'(cs_n), 32'd1);
    acceptOne();
    checkOutput("oneshot valid cleared", 32'(sample_valid), 32'd0);

    $display("[TB] padding error then clean frame");
    applyStimulus(16'b0000_0101_1010_0100, 8'h5A, 1'b1, 1'b0);
    pulseStart();
    waitEvent(0, 200, "pad valid", c);
    waitEvent(2, 20, "pad busy drop", c);
    acceptOne();
    applyStimulus(16'b0000_1111_0000_0000, 8'hF0, 1'b0, 1'b0);
    pulseStart();
    waitEvent(0, 200, "clean valid", c);
    waitEvent(2, 20, "clean busy drop", c);
    acceptOne();

    $display("[TB] continuous, period 200, ready held high");
    for (int i = 0; i < 5; i++) applyStimulus(16'b0000_0001_0010_0000, 8'h12, 1'b0, 1'b0);
    period = 24'd200;
    sample_ready = 1'b1;
    continuous = 1'b1;
    waitEvent(3, 20, "periodic first frame", c);
    for (int i = 0; i < 4; i++) begin
      waitEvent(3, 400, "periodic next frame", c);
      checkOutput("periodic spacing", 32'(c), 32'd200);
    end
    enable = 1'b0;
    waitEvent(2, 100, "periodic busy drop", c);
    tick(5);
    checkOutput("periodic results drained", 32'(exp_q.size()), 32'd0);
    checkOutput("periodic overrun", 32'(overrun), 32'd0);
    continuous = 1'b0;
    sample_ready = 1'b0;
    tick(2);

    $display("[TB] continuous, period 10, ready low");
    frame_bits = 16'b0000_0001_0001_0000;
    period = 24'd10;
    enable = 1'b1;
    continuous = 1'b1;
    waitEvent(3, 20, "b2b first frame", c);
    waitEvent(0, 200, "b2b first valid", c1);
    applyStimulus(16'b0000_0010_0010_0000, 8'h22, 1'b0, 1'b1);
    waitEvent(3, 200, "b2b second frame", c2);
    checkOutput("b2b spacing", 32'(c1 + c2), 32'd70);
    checkOutput("b2b no overrun yet", 32'(overrun), 32'd0);
    enable = 1'b0;
    waitEvent(1, 100, "b2b overrun", c);
    checkOutput("b2b valid held", 32'(sample_valid), 32'd1);
    waitEvent(2, 20, "b2b busy drop", c);
    acceptOne();
    checkOutput("b2b valid cleared", 32'(sample_valid), 32'd0);
    checkOutput("b2b overrun cleared", 32'(overrun), 32'd0);
    continuous = 1'b0;
    enable = 1'b1;
    tick(2);

    $display("[TB] reset in the middle of SHIFT");
    frame_bits = 16'b0000_0110_0110_0000;
    pulseStart();
    waitEvent(0, 200, "prereset valid", c);
    waitEvent(2, 20, "prereset busy drop", c);
    checkOutput("prereset valid pending", 32'(sample_valid), 32'd1);
    pulseStart();
    tick(22);
    checkOutput("midshift sck low", 32'(sck), 32'd0);
    checkOutput("midshift cs_n low", 32'(cs_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset cs_n", 32'(cs_n), 32'd1);
    checkOutput("async reset sck", 32'(sck), 32'd1);
    checkOutput("async reset valid", 32'(sample_valid), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset sample", 32'(sample), 32'd0);
    enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    cs0 = cs_falls;
    tick(100);
    checkOutput("post reset no frame", 32'(cs_falls - cs0), 32'd0);
    checkOutput("post reset cs_n", 32'(cs_n), 32'd1);
    checkOutput("post reset valid", 32'(sample_valid), 32'd0);

    $display("[TB] start while busy is ignored");
    enable = 1'b1;
    applyStimulus(16'b0000_1000_0001_0000, 8'h81, 1'b0, 1'b0);
    cs0 = cs_falls;
    pulseStart();
    tick(10);
    pulseStart();
    waitEvent(0, 200, "busy start valid", c);
    waitEvent(2, 20, "busy start busy drop", c);
    tick(100);
    checkOutput("busy start frame count", 32'(cs_falls - cs0), 32'd1);
    acceptOne();

    $display("[TB] enable dropped mid-frame in continuous mode");
    applyStimulus(16'b0000_0111_1110_0000, 8'h7E, 1'b0, 1'b0);
    period = 24'd200;
    cs0 = cs_falls;
    continuous = 1'b1;
    tick(20);
    enable = 1'b0;
    waitEvent(0, 100, "drop enable valid", c);
    waitEvent(2, 20, "drop enable busy drop", c);
    tick(300);
    checkOutput("drop enable frame count", 32'(cs_falls - cs0), 32'd1);
    checkOutput("drop enable idle busy", 32'(busy), 32'd0);
    checkOutput("drop enable valid held", 32'(sample_valid), 32'd1);
    acceptOne();
    continuous = 1'b0;

    tick(3);
    checkOutput("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
